control_unit: RTL
=================

# control_unit

Hardwired control unit for the single-bus datapath. Steps a Moore state machine through instruction fetch (T0–T2) and the execute steps of register-format ALU, negate/not, multiply/divide, nop and halt instructions. Drives every select, enable, read and ALU-opcode input of the datapath, replacing hand-sequenced testbench stimulus. Also provides a run/stop handshake to the outside world.

## Interface
- No parameters.
- clk  in  1  system clock; all state changes on rising edge
- clr  in  1  reset, asynchronous, active-high
- IR_Data  in  32  current IR contents from datapath; fields: op=[31:27], ra=[26:23], rb=[22:19], rc=[18:15]
- stop  in  1  request to halt at next instruction boundary
- go  in  1  leave HALT and resume fetching
- r_enable  out  16  one-hot register write enable (bit n = Rn)
- r_select  out  16  one-hot register bus-drive select
- PC_select, PC_enable, PC_increment_enable, IR_enable, Y_enable, Z_enable, MAR_enable, MDR_enable, HI_enable, LO_enable, Z_HI_select, Z_LO_select, MDR_select, read  out  1 each  datapath controls, same meaning as the datapath ports
- alu_instruction  out  5  ALU opcode
- run  out  1  1 while executing, 0 in RST/HALT
- state_dbg  out  4  current state encoding

## Operation
- States: RST, T0, T1, T2, T3, T4, T5, T6, HALT. Encoding is 0..8 in that order, visible on state_dbg.
- Outputs are a pure decode of state plus IR_Data. All outputs are 0 unless listed below. In RST and HALT every output is 0.
- T0: PC_select, MAR_enable, PC_increment_enable, Z_enable.
- T1: Z_LO_select, PC_enable, read, MDR_enable.
- T2: MDR_select, IR_enable.
- T3 onward, decoded from op:
  - ALU R-format, op 00011..01011 (add, sub, and, or, shr, shra, shl, ror, rol):
    - T3: r_select=1<<rb, Y_enable.
    - T4: r_select=1<<rc, alu_instruction=op, Z_enable.
    - T5: Z_LO_select, r_enable=1<<ra. Last step.
  - neg/not, op 10001/10010:
    - T3: r_select=1<<rb, alu_instruction=op, Z_enable.
    - T4: Z_LO_select, r_enable=1<<ra. Last step.
  - mul/div, op 01111/10000:
    - T3: r_select=1<<ra, Y_enable.
    - T4: r_select=1<<rb, alu_instruction=op, Z_enable.
    - T5: Z_LO_select, LO_enable.
    - T6: Z_HI_select, HI_enable. Last step.
  - nop (11010) and all unlisted opcodes: T2 is the last step.
  - halt (11011): T2 transitions to HALT.
- Transitions:
  - RST→T0.
  - T0→T1→T2.
  - From the last step: →HALT if stop=1, else →T0.
  - HALT→T0 when go=1; otherwise stays in HALT.
- stop is ignored on all steps that are not the last step. go is ignored outside HALT.
- At most one bit of r_enable and at most one bit of r_select is ever set. At most one bus driver is active in any state.

## Timing
- clr high: state=RST immediately. All outputs 0, run=0, state_dbg=0. State stays in RST while clr is held.
- First rising edge after clr falls: state→T0.
- Each step lasts exactly one clock. Datapath registers capture at the rising edge that ends the step.
- IR is loaded at the end of T2. T3 decode therefore uses the new IR_Data; T2's own last-step decisions (nop/halt/illegal) also read IR_Data, which the datapath must make visible combinationally from the MDR bus path by the end of T2. A halt or nop is detected one edge after IR load.
- Instruction latency, fetch to T0 of the next instruction:
  - ALU R-format: 6 clocks
  - neg/not: 5 clocks
  - mul/div: 7 clocks
  - nop: 3 clocks
- stop and go are sampled at the rising edge; there is no synchronizer.
- clr asserted mid-instruction aborts at once. Partially executed instructions are not replayed.

## Configuration
- CU_MULDIV_EN defined: mul/div sequences T3–T6 are as specified.
- CU_MULDIV_EN undefined:
  - op 01111/10000 decode as nop (T2 is the last step).
  - HI_enable, LO_enable and Z_HI_select are tied to 0.
  - State T6 is unreachable; it transitions to T0 if ever entered.

## Test plan
- Reset: assert clr for 2 cycles then release → outputs all 0, run=0 during reset; state_dbg=1 (T0) after the first edge, with PC_select=MAR_enable=PC_increment_enable=Z_enable=1.
- and R1,R2,R3 (IR=0x28918000):
  - T3: r_select=0x0004, Y_enable=1.
  - T4: r_select=0x0008, alu_instruction=5, Z_enable=1.
  - T5: Z_LO_select=1, r_enable=0x0002.
  - Next: T0.
- mul R4,R1 (IR=0x7A080000), CU_MULDIV_EN defined:
  - T3: r_select=0x0010.
  - T4: r_select=0x0002, alu_instruction=15.
  - T5: LO_enable=1.
  - T6: HI_enable=1.
  - Same IR without the macro → T2→T0 with no HI/LO writes.
- halt (IR=0xD8000000) → HALT after T2, run=0. Hold go=0 for 5 cycles → stays in HALT. Pulse go=1 → T0.
- stop=1 asserted during T3 of an add → instruction completes T5, then HALT. stop=1 during T1 of a nop (0xD0000000) → HALT after T2.
- clr pulsed during T4 of an add → immediate RST with all outputs 0, no r_enable pulse, then T0 on the next edge.

Source files
------------

// File: rtl/control_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : control_unit_if
//  Description : Bundle between the hardwired control unit and the single-bus
//                datapath: IR contents and run/stop handshake in, every
//                datapath select/enable/read/ALU-opcode control out.
//                master = control unit side, slave = datapath/environment.
//  Revision    : 1.0  initial release
// ============================================================================
interface control_unit_if;
  logic [31:0] IR_Data;
  logic        stop;
  logic        go;
  logic [15:0] r_enable;
  logic [15:0] r_select;
  logic        PC_select;
  logic        PC_enable;
  logic        PC_increment_enable;
  logic        IR_enable;
  logic        Y_enable;
  logic        Z_enable;
  logic        MAR_enable;
  logic        MDR_enable;
  logic        HI_enable;
  logic        LO_enable;
  logic        Z_HI_select;
  logic        Z_LO_select;
  logic        MDR_select;
  logic        read;
  logic [4:0]  alu_instruction;
  logic        run;
  logic [3:0]  state_dbg;

  modport master (
    input  IR_Data, stop, go,
    output r_enable, r_select, PC_select, PC_enable, PC_increment_enable,
           IR_enable, Y_enable, Z_enable, MAR_enable, MDR_enable, HI_enable,
           LO_enable, Z_HI_select, Z_LO_select, MDR_select, read,
           alu_instruction, run, state_dbg
  );

  modport slave (
    output IR_Data, stop, go,
    input  r_enable, r_select, PC_select, PC_enable, PC_increment_enable,
           IR_enable, Y_enable, Z_enable, MAR_enable, MDR_enable, HI_enable,
           LO_enable, Z_HI_select, Z_LO_select, MDR_select, read,
           alu_instruction, run, state_dbg
  );
endinterface
`default_nettype wire

// File: rtl/control_unit.sv
`default_nettype none
// ============================================================================
//  Module      : control_unit
//  Description : Hardwired Moore control unit for the single-bus datapath.
//                Sequences fetch (T0-T2) and the execute steps of R-format
//                ALU, neg/not, mul/div, nop and halt instructions, with a
//                run/stop/go handshake. Outputs are registered: the decode of
//                the next state and the IR fields is captured at each edge.
//                Optional feature macro: CU_MULDIV_EN (mul/div sequences;
//                without it mul/div decode as nop and HI/LO writes are 0).
//  Revision    : 1.0  initial release
// ============================================================================
module control_unit (
  input  logic           clk,
  input  logic           clr,
  control_unit_if.master cu
);

`ifdef CU_MULDIV_EN
  localparam logic c_MULDIV_EN = 1'b1;
`else
  localparam logic c_MULDIV_EN = 1'b0;
`endif

  typedef enum logic [3:0] {
    ST_RST  = 4'd0,
    ST_T0   = 4'd1,
    ST_T1   = 4'd2,
    ST_T2   = 4'd3,
    ST_T3   = 4'd4,
    ST_T4   = 4'd5,
    ST_T5   = 4'd6,
    ST_T6   = 4'd7,
    ST_HALT = 4'd8
  } state_t;

  typedef struct packed {
    logic [15:0] ren;
    logic [15:0] rsel;
    logic        pc_select;
    logic        pc_enable;
    logic        pc_inc;
    logic        ir_en;
    logic        y_en;
    logic        z_en;
    logic        mar_en;
    logic        mdr_en;
    logic        hi_en;
    logic        lo_en;
    logic        z_hi_sel;
    logic        z_lo_sel;
    logic        mdr_sel;
    logic        rd;
    logic [4:0]  alu_op;
  } ctrl_t;

  state_t r_state;
  state_t w_next;
  ctrl_t  r_ctrl;
  ctrl_t  w_ctrl;
  logic   r_run;

  // IR field extraction and opcode classification
  logic [4:0] w_op;
  logic [3:0] w_ra, w_rb, w_rc;
  logic       w_is_alu, w_is_negnot, w_is_muldiv, w_is_halt;
  logic       w_last;
  state_t     w_end;
  logic       w_unused_ir;

  assign w_op        = cu.IR_Data[31:27];
  assign w_ra        = cu.IR_Data[26:23];
  assign w_rb        = cu.IR_Data[22:19];
  assign w_rc        = cu.IR_Data[18:15];
  assign w_unused_ir = &{1'b0, cu.IR_Data[14:0]};

  assign w_is_alu    = (w_op >= 5'd3) && (w_op <= 5'd11);
  assign w_is_negnot = (w_op == 5'd17) || (w_op == 5'd18);
  assign w_is_muldiv = c_MULDIV_EN && ((w_op == 5'd15) || (w_op == 5'd16));
  assign w_is_halt   = (w_op == 5'd27);

  // Where an instruction ends, stop decides between halting and refetching
  assign w_end = cu.stop ? ST_HALT : ST_T0;

  // Is the current step the final step of the instruction in the IR
  always_comb begin
    w_last = 1'b0;
    case (r_state)
      ST_T2:   w_last = !(w_is_alu || w_is_negnot || w_is_muldiv);
      ST_T4:   w_last = w_is_negnot;
      ST_T5:   w_last = w_is_alu;
      ST_T6:   w_last = w_is_muldiv;
      default: w_last = 1'b0;
    endcase
  end

  // Next-state selection
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_RST:  w_next = ST_T0;
      ST_T0:   w_next = ST_T1;
      ST_T1:   w_next = ST_T2;
      ST_T2:   w_next = w_is_halt ? ST_HALT : (w_last ? w_end : ST_T3);
      ST_T3:   w_next = ST_T4;
      ST_T4:   w_next = w_last ? w_end : ((w_is_alu || w_is_muldiv) ? ST_T5 : ST_T0);
      ST_T5:   w_next = w_last ? w_end : (w_is_muldiv ? ST_T6 : ST_T0);
      // T6 is only a real step for mul/div; anything else just refetches
      ST_T6:   w_next = w_last ? w_end : ST_T0;
      ST_HALT: w_next = cu.go ? ST_T0 : ST_HALT;
      default: w_next = ST_RST;
    endcase
  end

  // Control word for the state being entered, decoded from the IR fields
  always_comb begin
    w_ctrl = '0;
    case (w_next)
      ST_T0: begin
        w_ctrl.pc_select = 1'b1;
        w_ctrl.mar_en    = 1'b1;
        w_ctrl.pc_inc    = 1'b1;
        w_ctrl.z_en      = 1'b1;
      end
      ST_T1: begin
        w_ctrl.z_lo_sel  = 1'b1;
        w_ctrl.pc_enable = 1'b1;
        w_ctrl.rd        = 1'b1;
        w_ctrl.mdr_en    = 1'b1;
      end
      ST_T2: begin
        w_ctrl.mdr_sel = 1'b1;
        w_ctrl.ir_en   = 1'b1;
      end
      ST_T3: begin
        if (w_is_alu) begin
          w_ctrl.rsel = 16'h0001 << w_rb;
          w_ctrl.y_en = 1'b1;
        end else if (w_is_negnot) begin
          w_ctrl.rsel   = 16'h0001 << w_rb;
          w_ctrl.alu_op = w_op;
          w_ctrl.z_en   = 1'b1;
        end else if (w_is_muldiv) begin
          w_ctrl.rsel = 16'h0001 << w_ra;
          w_ctrl.y_en = 1'b1;
        end
      end
      ST_T4: begin
        if (w_is_alu) begin
          w_ctrl.rsel   = 16'h0001 << w_rc;
          w_ctrl.alu_op = w_op;
          w_ctrl.z_en   = 1'b1;
        end else if (w_is_negnot) begin
          w_ctrl.z_lo_sel = 1'b1;
          w_ctrl.ren      = 16'h0001 << w_ra;
        end else if (w_is_muldiv) begin
          w_ctrl.rsel   = 16'h0001 << w_rb;
          w_ctrl.alu_op = w_op;
          w_ctrl.z_en   = 1'b1;
        end
      end
      ST_T5: begin
        if (w_is_alu) begin
          w_ctrl.z_lo_sel = 1'b1;
          w_ctrl.ren      = 16'h0001 << w_ra;
        end else if (w_is_muldiv) begin
          w_ctrl.z_lo_sel = 1'b1;
          w_ctrl.lo_en    = 1'b1;
        end
      end
      ST_T6: begin
        if (w_is_muldiv) begin
          w_ctrl.z_hi_sel = 1'b1;
          w_ctrl.hi_en    = 1'b1;
        end
      end
      default: w_ctrl = '0;
    endcase
  end

  // State register and registered control outputs; clr aborts immediately
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state <= ST_RST;
      r_ctrl  <= '0;
      r_run   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ctrl  <= w_ctrl;
      r_run   <= (w_next != ST_RST) && (w_next != ST_HALT);
    end
  end

  assign cu.r_enable            = r_ctrl.ren;
  assign cu.r_select            = r_ctrl.rsel;
  assign cu.PC_select           = r_ctrl.pc_select;
  assign cu.PC_enable           = r_ctrl.pc_enable;
  assign cu.PC_increment_enable = r_ctrl.pc_inc;
  assign cu.IR_enable           = r_ctrl.ir_en;
  assign cu.Y_enable            = r_ctrl.y_en;
  assign cu.Z_enable            = r_ctrl.z_en;
  assign cu.MAR_enable          = r_ctrl.mar_en;
  assign cu.MDR_enable          = r_ctrl.mdr_en;
  assign cu.HI_enable           = r_ctrl.hi_en & c_MULDIV_EN;
  assign cu.LO_enable           = r_ctrl.lo_en & c_MULDIV_EN;
  assign cu.Z_HI_select         = r_ctrl.z_hi_sel & c_MULDIV_EN;
  assign cu.Z_LO_select         = r_ctrl.z_lo_sel;
  assign cu.MDR_select          = r_ctrl.mdr_sel;
  assign cu.read                = r_ctrl.rd;
  assign cu.alu_instruction     = r_ctrl.alu_op;
  assign cu.run                 = r_run;
  assign cu.state_dbg           = r_state;

endmodule
`default_nettype wire
